video_sync_detect: RTL

Timing recovery block for the PCW video path, the receiving end of the sync generator's hs/vs/blank outputs. It measures line length and frame height, detects PAL or NTSC framing, and qualifies lock over whole frames. It also regenerates active-area x/y coordinates for downstream consumers such as the OSD/scaler. It runs in the pixel domain and samples its inputs only on pixel strobes.

---
 rtl/pcw_video_pkg.sv | 19 +
 rtl/sync_edge.sv | 37 +++
 rtl/video_sync_detect.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pcw_video_pkg.sv
// pcw_video_pkg: values shared by the PCW sync generator and the sync detector
// so both ends agree on framing.
//   PAL_LINES / NTSC_LINES : default frame heights for classification
//   LINE_LEN               : nominal strobes per line from the generator
//   sync_state_t           : lock qualification states of the detector
package pcw_video_pkg;

  localparam int PAL_LINES  = 312;
  localparam int NTSC_LINES = 260;
  localparam int LINE_LEN   = 1024;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    VERIFY,
    LOCKED
  } sync_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: strobe-qualified input sample with edge pulses.
//   i_clk, i_rst : clock, async active-high reset
//   i_stb        : pixel strobe; sample and history only move when high
//   i_d          : raw input level
//   o_q          : registered sample
//   o_rise/o_fall: single-clock pulses, only asserted while i_stb is high
// Both the sample and the history reset to 1 (inactive for the active-low
// syncs, blanked for the blanks), so the first edge after reset is real
// only if the input is actually low.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic q_q, prev_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_q    <= 1'b1;
      prev_q <= 1'b1;
    end else if (i_stb) begin
      q_q    <= i_d;
      prev_q <= q_q;
    end
  end

  assign o_q    = q_q;
  // Gated by the strobe so a held level between strobes is not seen twice.
  assign o_rise = i_stb & ~prev_q &  q_q;
  assign o_fall = i_stb &  prev_q & ~q_q;

endmodule

// File: rtl/video_sync_detect.sv
// video_sync_detect: recovers line/frame timing from hs/vs/blank, classifies
// PAL/NTSC, qualifies lock over whole frames and regenerates active x/y.
//   i_clk, i_rst     : clock, async active-high reset
//   i_pix_stb        : pixel strobe, all sampling/counting advance on it
//   i_hs, i_vs       : active-low syncs
//   i_hblank, i_vblank: blanking levels
//   o_locked, o_ntsc : lock status and framing class (valid while locked)
//   o_line_len       : strobes between hs falls (latched by the FSM)
//   o_frame_lines    : hs falls per frame (latched by the FSM)
//   o_x, o_y         : active pixel / line index
//   o_line_start, o_frame_start, o_err : one-clock pulses
// All outputs are registered; inputs are seen two strobes late.
module video_sync_detect #(
  parameter int TIMEOUT    = 2047,
  parameter int PAL_LINES  = pcw_video_pkg::PAL_LINES,
  parameter int NTSC_LINES = pcw_video_pkg::NTSC_LINES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_hblank,
  input  logic        i_vblank,
  output logic        o_locked,
  output logic        o_ntsc,
  output logic [10:0] o_line_len,
  output logic [9:0]  o_frame_lines,
  output logic [10:0] o_x,
  output logic [8:0]  o_y,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic        o_err
);
  import pcw_video_pkg::*;

  localparam int HS = 0, VS = 1, HB = 2, VB = 3;

  // Input stage
  logic [3:0] raw, smp, rise, fall;
  assign raw = {i_vblank, i_hblank, i_vs, i_hs};

  for (genvar g = 0; g < 4; g++) begin : g_edge
    sync_edge u_edge (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_stb  (i_pix_stb),
      .i_d    (raw[g]),
      .o_q    (smp[g]),
      .o_rise (rise[g]),
      .o_fall (fall[g])
    );
  end

  logic hs_fall, vs_fall, hb, vb, hb_rise, hb_fall, vb_fall;
  assign hs_fall = fall[HS];
  assign vs_fall = fall[VS];
  assign hb      = smp[HB];
  assign vb      = smp[VB];
  assign hb_rise = rise[HB];
  assign hb_fall = fall[HB];
  assign vb_fall = fall[VB];

  // Sync levels and sync rises carry no information here; PAL is simply
  // "not NTSC", so its height value is not needed by the logic.
  logic unused_sig;
  assign unused_sig = ^{rise[HS], rise[VS], rise[VB], smp[HS], smp[VS]} ^ (PAL_LINES == 0);

  // State
  sync_state_t state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d, last_len_q, last_len_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        line_ok_q, line_ok_d, first_q, first_d;
  logic [10:0] line_len_q, line_len_d, x_q, x_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic [8:0]  y_q, y_d;
  logic        ntsc_q, ntsc_d, locked_q, err_q, err_d, ls_q, fs_q;

  // Lock qualification terms
  logic        timeout, len_bad, line_ok_now, match, latch_en, enter_lock;
  logic [10:0] cand_len;

  assign timeout  = i_pix_stb && (state_q != SEARCH) && (h_cnt_q == 11'(TIMEOUT));
  assign len_bad  = (h_cnt_q != line_len_q);
  // A frame that closes on an hs fall also closes its last line; fold that
  // line's check in, since line_ok_q only reflects earlier lines.
  assign line_ok_now = line_ok_q && !(hs_fall && !first_q && len_bad);
  assign match    = (v_cnt_q == frame_lines_q) && line_ok_now;
  assign cand_len = hs_fall ? h_cnt_q : last_len_q;

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = SEARCH;
    end else if (vs_fall) begin
      case (state_q)
        SEARCH:  state_d = MEASURE;
        MEASURE: state_d = VERIFY;
        VERIFY:  if (match)  state_d = LOCKED;
        LOCKED:  if (!match) state_d = VERIFY;
        default: state_d = SEARCH;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    latch_en = 1'b0;
    err_d    = timeout;
    if (!timeout && vs_fall) begin
      case (state_q)
        MEASURE: latch_en = 1'b1;
        VERIFY:  latch_en = !match;
        LOCKED: begin
          latch_en = !match;
          err_d    = !match;
        end
        default: latch_en = 1'b0;
      endcase
    end
    enter_lock    = (state_d == LOCKED) && (state_q != LOCKED);
    line_len_d    = latch_en ? cand_len : line_len_q;
    frame_lines_d = latch_en ? v_cnt_q  : frame_lines_q;
    ntsc_d        = enter_lock ? (v_cnt_q == 10'(NTSC_LINES)) : ntsc_q;
  end

  // Measurement counters and active-area coordinates
  always_comb begin
    h_cnt_d    = h_cnt_q;
    last_len_d = last_len_q;
    v_cnt_d    = v_cnt_q;
    line_ok_d  = line_ok_q;
    first_d    = first_q;
    x_d        = x_q;
    y_d        = y_q;

    if (hs_fall) begin
      h_cnt_d    = 11'd1;
      last_len_d = h_cnt_q;
    end else if (i_pix_stb && h_cnt_q != '1) begin
      h_cnt_d = h_cnt_q + 11'd1;
    end

    // A coincident hs fall is line 1 of the new frame.
    if (vs_fall)                      v_cnt_d = hs_fall ? 10'd1 : 10'd0;
    else if (hs_fall && v_cnt_q != '1) v_cnt_d = v_cnt_q + 10'd1;

    // The first line after vs may be partial, so it is not compared.
    if (vs_fall) begin
      line_ok_d = 1'b1;
      first_d   = 1'b1;
    end else if (hs_fall) begin
      first_d = 1'b0;
      if (!first_q && len_bad) line_ok_d = 1'b0;
    end

    if (i_pix_stb) begin
      // x restarts on the first active sample after any blanking.
      if (hb || vb || hb_fall || vb_fall) x_d = '0;
      else if (x_q != '1)                 x_d = x_q + 11'd1;
      // vblank clear takes priority over the hblank-rise increment.
      if (vb)                          y_d = '0;
      else if (hb_rise && y_q != '1)   y_d = y_q + 9'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt_q       <= '0;
      last_len_q    <= '0;
      v_cnt_q       <= '0;
      line_ok_q     <= 1'b0;
      first_q       <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      ntsc_q        <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      ls_q          <= 1'b0;
      fs_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      last_len_q    <= last_len_d;
      v_cnt_q       <= v_cnt_d;
      line_ok_q     <= line_ok_d;
      first_q       <= first_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      ntsc_q        <= ntsc_d;
      locked_q      <= (state_d == LOCKED);
      err_q         <= err_d;
      ls_q          <= hs_fall;
      fs_q          <= vs_fall;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  assign o_locked      = locked_q;
  assign o_ntsc        = ntsc_q;
  assign o_line_len    = line_len_q;
  assign o_frame_lines = frame_lines_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = ls_q;
  assign o_frame_start = fs_q;
  assign o_err         = err_q;

endmodule
